// File: rtl/test_monitor_pkg.sv
// Shared definitions for the test monitor: FSM encoding, default register
// indices and a saturating adder for the optional write counter.
package test_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2,
        VERDICT = 2'd3
    } state_t;

    localparam int DEF_DONE_REG = 26;
    localparam int DEF_PASS_REG = 27;
    localparam int DEF_TNUM_REG = 3;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [2:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {30'd0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/test_monitor_hart.sv
// Per-hart shadow registers for done / pass / test-number, fed by one
// snooped register-file write port. pass/tnum next-values are exported so the
// verdict includes a write landing in the last DRAIN cycle.
module test_monitor_hart #(
    parameter int DONE_REG = 26,
    parameter int PASS_REG = 27,
    parameter int TNUM_REG = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        active,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic        pass_nxt,
    output logic [31:0] tnum_nxt
);

    localparam logic [4:0] DONE_A = 5'(DONE_REG);
    localparam logic [4:0] PASS_A = 5'(PASS_REG);
    localparam logic [4:0] TNUM_A = 5'(TNUM_REG);

    logic        acc;
    logic        pass_q;
    logic [31:0] tnum_q;

    assign acc = active && we && (waddr != 5'd0);

    // next values of the pass and test-number shadows
    always_comb begin
        pass_nxt = pass_q;
        tnum_nxt = tnum_q;
        if (acc && waddr == PASS_A) pass_nxt = (wdata == 32'd1);
        if (acc && waddr == TNUM_A) tnum_nxt = wdata;
    end

    // shadow registers; done is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            done   <= 1'b0;
            pass_q <= 1'b0;
            tnum_q <= '0;
        end else begin
            if (acc && waddr == DONE_A && wdata == 32'd1) done <= 1'b1;
            pass_q <= pass_nxt;
            tnum_q <= tnum_nxt;
        end
    end

endmodule

// File: rtl/test_monitor.sv
// Test-end monitor: snoops NUM_HARTS register-file write ports, waits for all
// harts to signal done, lets results settle for DRAIN_CYCLES, then latches a
// sticky verdict (or a timeout verdict).
// Optional macro TEST_MONITOR_WRCNT_EN enables the saturating accepted-write
// counter on wr_cnt_o; otherwise wr_cnt_o is tied to 0.
//
//   state   | meaning
//   IDLE    | waiting for en_i, writes ignored
//   RUN     | snooping, waiting for every hart's done shadow
//   DRAIN   | all done, still capturing pass/tnum for DRAIN_CYCLES
//   VERDICT | outputs frozen until reset
module test_monitor
    import test_monitor_pkg::*;
#(
    parameter int NUM_HARTS      = 1,
    parameter int DONE_REG       = DEF_DONE_REG,
    parameter int PASS_REG       = DEF_PASS_REG,
    parameter int TNUM_REG       = DEF_TNUM_REG,
    parameter int TIMEOUT_CYCLES = 250000,
    parameter int DRAIN_CYCLES   = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic [NUM_HARTS-1:0]    we_i,
    input  logic [5*NUM_HARTS-1:0]  waddr_i,
    input  logic [32*NUM_HARTS-1:0] wdata_i,
    output logic                    done_o,
    output logic                    pass_o,
    output logic                    timeout_o,
    output logic [1:0]              fail_hart_o,
    output logic [31:0]             fail_tnum_o,
    output logic [31:0]             wr_cnt_o
);

    state_t                state;
    logic [31:0]           to_cnt;
    logic [31:0]           dr_cnt;
    logic                  active;
    logic [NUM_HARTS-1:0]  done_v;
    logic [NUM_HARTS-1:0]  pass_v;
    logic [31:0]           tnum_v [NUM_HARTS];
    logic                  all_done;
    logic                  fin_ok;
    logic                  fin_to;
    logic [1:0]            v_hart;
    logic [31:0]           v_tnum;

    assign active   = (state == RUN) || (state == DRAIN);
    assign all_done = &done_v;

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        test_monitor_hart #(
            .DONE_REG(DONE_REG),
            .PASS_REG(PASS_REG),
            .TNUM_REG(TNUM_REG)
        ) u_hart (
            .clk     (clk),
            .rst     (rst),
            .active  (active),
            .we      (we_i[h]),
            .waddr   (waddr_i[5*h +: 5]),
            .wdata   (wdata_i[32*h +: 32]),
            .done    (done_v[h]),
            .pass_nxt(pass_v[h]),
            .tnum_nxt(tnum_v[h])
        );
    end

    // lowest failing hart (hart 0 when nobody failed) and its test number
    always_comb begin
        v_hart = 2'd0;
        v_tnum = tnum_v[0];
        for (int h = NUM_HARTS - 1; h >= 0; h--) begin
            if (!pass_v[h]) begin
                v_hart = 2'(h);
                v_tnum = tnum_v[h];
            end
        end
    end

    // verdict decision this cycle; completion wins over an expiring timer
    always_comb begin
        fin_ok = 1'b0;
        fin_to = 1'b0;
        case (state)
            RUN: begin
                if (all_done) fin_ok = (DRAIN_CYCLES == 0);
                else          fin_to = (to_cnt == 32'd0);
            end
            DRAIN: begin
                if (dr_cnt == 32'd0) fin_ok = 1'b1;
                else                 fin_to = (to_cnt == 32'd0);
            end
            default: ;
        endcase
    end

    // sequencing FSM with down-counting timers and registered verdict outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            to_cnt      <= '0;
            dr_cnt      <= '0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            timeout_o   <= 1'b0;
            fail_hart_o <= '0;
            fail_tnum_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_i) begin
                        state  <= RUN;
                        to_cnt <= 32'(TIMEOUT_CYCLES - 1);
                    end
                end
                RUN: begin
                    to_cnt <= to_cnt - 32'd1;
                    if (all_done && DRAIN_CYCLES != 0) begin
                        state  <= DRAIN;
                        dr_cnt <= 32'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    to_cnt <= to_cnt - 32'd1;
                    dr_cnt <= dr_cnt - 32'd1;
                end
                default: ;
            endcase
            if (fin_ok || fin_to) begin
                state       <= VERDICT;
                done_o      <= 1'b1;
                timeout_o   <= fin_to;
                pass_o      <= fin_ok && (&pass_v);
                fail_hart_o <= v_hart;
                fail_tnum_o <= v_tnum;
            end
        end
    end

`ifdef TEST_MONITOR_WRCNT_EN
    logic [2:0]  n_acc;
    logic [31:0] wr_cnt_q;

    // number of accepted writes across all harts this cycle
    always_comb begin
        n_acc = 3'd0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (active && we_i[h] && waddr_i[5*h +: 5] != 5'd0) n_acc = n_acc + 3'd1;
        end
    end

    // saturating accepted-write counter
    always_ff @(posedge clk) begin
        if (rst) wr_cnt_q <= '0;
        else     wr_cnt_q <= sat_add(wr_cnt_q, n_acc);
    end

    assign wr_cnt_o = wr_cnt_q;
`else
    assign wr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_test_monitor.sv
// Bench for test_monitor: a single-hart and a dual-hart instance with a
// 100-cycle timeout and 5-cycle drain; directed scenarios plus a randomized
// run checked against a cycle-index model of verdict timing and contents.
module tb_test_monitor;
    import test_monitor_pkg::*;

    localparam int T = 100;
    localparam int D = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [0:0]  we1 = '0;
    logic [4:0]  waddr1 = '0;
    logic [31:0] wdata1 = '0;
    logic [1:0]  we2 = '0;
    logic [9:0]  waddr2 = '0;
    logic [63:0] wdata2 = '0;
    logic        done1, pass1, to1, done2, pass2, to2;
    logic [1:0]  fh1, fh2;
    logic [31:0] ft1, ft2, wc1, wc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    test_monitor #(.NUM_HARTS(1), .TIMEOUT_CYCLES(T), .DRAIN_CYCLES(D)) u1 (
        .clk(clk), .rst(rst), .en_i(en), .we_i(we1), .waddr_i(waddr1), .wdata_i(wdata1),
        .done_o(done1), .pass_o(pass1), .timeout_o(to1), .fail_hart_o(fh1),
        .fail_tnum_o(ft1), .wr_cnt_o(wc1));

    test_monitor #(.NUM_HARTS(2), .TIMEOUT_CYCLES(T), .DRAIN_CYCLES(D)) u2 (
        .clk(clk), .rst(rst), .en_i(en), .we_i(we2), .waddr_i(waddr2), .wdata_i(wdata2),
        .done_o(done2), .pass_o(pass2), .timeout_o(to2), .fail_hart_o(fh2),
        .fail_tnum_o(ft2), .wr_cnt_o(wc2));

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; we1 = '0; we2 = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // en pulse; returns at the negedge of RUN cycle 0 with en already dropped
    task automatic start();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d);
        we1 = 1'b1; waddr1 = a; wdata1 = d;
        @(negedge clk);
        we1 = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({done1, pass1, to1, fh1, ft1, wc1} !== '0 || {done2, pass2, to2, fh2, ft2, wc2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got1=%b/%b/%b/%0d/%0d/%0d got2=%b/%b/%b/%0d/%0d/%0d exp=all zero",
                     done1, pass1, to1, fh1, ft1, wc1, done2, pass2, to2, fh2, ft2, wc2);
        end
        checks++;
        if (u1.state !== IDLE || u2.state !== IDLE) begin
            errors++;
            $display("FAIL reset_state got=%0d/%0d exp=IDLE", u1.state, u2.state);
        end
    endtask

    task automatic test_pass();
        do_reset();
        start();
        wr1(5'd27, 32'd1);
        wr1(5'd26, 32'd1);
        @(negedge clk);
        checks++;
        if (u1.state !== DRAIN) begin
            errors++; $display("FAIL pass_drain_entry got=%0d exp=%0d", u1.state, DRAIN);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (done1 !== 1'b0 || u1.state !== DRAIN) begin
            errors++; $display("FAIL pass_drain_len done=%b state=%0d exp done=0 state=DRAIN", done1, u1.state);
        end
        @(negedge clk);
        checks++;
        if ({done1, pass1, to1} !== 3'b110) begin
            errors++; $display("FAIL pass_verdict got done/pass/to=%b%b%b exp=110", done1, pass1, to1);
        end
    endtask

    task automatic test_fail();
        bit seen = 0;
        do_reset();
        start();
        wr1(5'd3, 32'd7);
        wr1(5'd27, 32'd0);
        wr1(5'd26, 32'd1);
        for (int i = 0; i < 50 && !seen; i++) begin
            if (done1) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL fail_wait done_o=%b exp=1 within 50 cycles", done1);
        end
        checks++;
        if (pass1 !== 1'b0 || to1 !== 1'b0 || fh1 !== 2'd0 || ft1 !== 32'd7) begin
            errors++; $display("FAIL fail_verdict got pass=%b to=%b hart=%0d tnum=%0d exp 0/0/0/7", pass1, to1, fh1, ft1);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        start();
        repeat (T - 1) @(negedge clk);
        checks++;
        if (done1 !== 1'b0) begin
            errors++; $display("FAIL timeout_early got done=%b exp=0 at cycle %0d", done1, T - 1);
        end
        @(negedge clk);
        checks++;
        if ({done1, pass1, to1} !== 3'b101) begin
            errors++; $display("FAIL timeout_verdict got done/pass/to=%b%b%b exp=101", done1, pass1, to1);
        end
    endtask

    task automatic test_two_hart();
        bit seen = 0;
        do_reset();
        start();
        we2 = 2'b11; waddr2 = {5'd3, 5'd27}; wdata2 = {32'd4, 32'd1};
        @(negedge clk);
        we2 = 2'b10; waddr2 = {5'd27, 5'd0}; wdata2 = {32'd0, 32'd0};
        @(negedge clk);
        we2 = 2'b11; waddr2 = {5'd26, 5'd26}; wdata2 = {32'd1, 32'd1};
        @(negedge clk);
        we2 = 2'b00;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (done2) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL two_hart_wait done_o=%b exp=1 within 50 cycles", done2);
        end
        checks++;
        if (pass2 !== 1'b0 || to2 !== 1'b0 || fh2 !== 2'd1 || ft2 !== 32'd4) begin
            errors++; $display("FAIL two_hart_verdict got pass=%b to=%b hart=%0d tnum=%0d exp 0/0/1/4", pass2, to2, fh2, ft2);
        end
    endtask

    task automatic test_done_on_timeout();
        do_reset();
        start();
        repeat (T - 2) @(negedge clk);
        wr1(5'd26, 32'd1);
        @(negedge clk);
        checks++;
        if (u1.state !== DRAIN || to1 !== 1'b0 || done1 !== 1'b0) begin
            errors++; $display("FAIL done_priority got state=%0d to=%b done=%b exp DRAIN/0/0", u1.state, to1, done1);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (u1.state !== IDLE || {done1, pass1, to1, fh1, ft1, wc1} !== '0) begin
            errors++; $display("FAIL drain_reset got state=%0d done=%b pass=%b to=%b hart=%0d tnum=%0d cnt=%0d exp IDLE/all zero",
                               u1.state, done1, pass1, to1, fh1, ft1, wc1);
        end
        rst = 1'b0;
    endtask

    task automatic test_wrcnt();
        int exp_cnt;
        do_reset();
        we2 = 2'b11; waddr2 = {5'd6, 5'd5}; wdata2 = {32'd9, 32'd8};
        @(negedge clk);
        we2 = 2'b00;
        start();
        repeat (3) begin
            we2 = 2'b11; waddr2 = {5'd6, 5'd5}; wdata2 = {$urandom, $urandom};
            @(negedge clk);
        end
        we2 = 2'b01; waddr2 = {5'd6, 5'd0}; wdata2 = {32'd0, 32'd1};
        @(negedge clk);
        we2 = 2'b00;
        @(negedge clk);
`ifdef TEST_MONITOR_WRCNT_EN
        exp_cnt = 6;
`else
        exp_cnt = 0;
`endif
        checks++;
        if (wc2 !== 32'(exp_cnt)) begin
            errors++; $display("FAIL wrcnt got=%0d exp=%0d", wc2, exp_cnt);
        end
        checks++;
        if (done2 !== 1'b0) begin
            errors++; $display("FAIL wrcnt_no_end got done=%b exp=0", done2);
        end
    endtask

    // Model: writes in cycle j are accepted iff j < v, the verdict cycle.
    // The last done write at cycle jl gives v = jl + 2 + D, capped by T.
    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int nwr, v, jl, cnt, k, fh_exp;
            bit alld, to_exp, no_done, pass_exp;
            bit [1:0] dn, ps;
            logic [31:0] tn [2];
            logic [4:0] a;
            logic [31:0] d;
            nwr = $urandom_range(8, 98);
            no_done = ($urandom_range(0, 3) == 0);
            v = T; jl = 0; cnt = 0; alld = 0; dn = '0; ps = '0;
            tn[0] = '0; tn[1] = '0;
            do_reset();
            start();
            for (int j = 0; j <= T + 1; j++) begin
                checks++;
                if (done2 !== (j >= v)) begin
                    errors++; $display("FAIL rand_done it=%0d cyc=%0d got=%b exp=%b", it, j, done2, (j >= v));
                end
                we2 = '0;
                if (j < nwr) begin
                    for (int h = 0; h < 2; h++) begin
                        if ($urandom_range(0, 2) != 0) begin
                            k = $urandom_range(0, 4);
                            case (k)
                                0: a = 5'd0;
                                1: a = 5'd3;
                                2: a = no_done ? 5'd25 : 5'd26;
                                3: a = 5'd27;
                                default: a = 5'($urandom_range(1, 31));
                            endcase
                            k = $urandom_range(0, 3);
                            d = (k == 0) ? 32'd0 : (k == 1) ? 32'($urandom) : 32'd1;
                            we2[h] = 1'b1;
                            waddr2[5*h +: 5] = a;
                            wdata2[32*h +: 32] = d;
                            if (j < v && a != 5'd0) begin
                                cnt++;
                                if (a == 5'd26 && d == 32'd1) dn[h] = 1'b1;
                                if (a == 5'd27) ps[h] = (d == 32'd1);
                                if (a == 5'd3)  tn[h] = d;
                            end
                        end
                    end
                end
                if (!alld && dn == 2'b11) begin
                    alld = 1; jl = j;
                    v = (j + 2 + D < T) ? j + 2 + D : T;
                end
                @(negedge clk);
            end
            we2 = '0;
            to_exp   = !alld || (jl + 2 + D > T);
            pass_exp = !to_exp && (ps == 2'b11);
            fh_exp   = !ps[0] ? 0 : (!ps[1] ? 1 : 0);
`ifndef TEST_MONITOR_WRCNT_EN
            cnt = 0;
`endif
            checks++;
            if (to2 !== to_exp || pass2 !== pass_exp) begin
                errors++; $display("FAIL rand_verdict it=%0d got to=%b pass=%b exp to=%b pass=%b", it, to2, pass2, to_exp, pass_exp);
            end
            checks++;
            if (fh2 !== 2'(fh_exp) || ft2 !== tn[fh_exp]) begin
                errors++; $display("FAIL rand_fail_info it=%0d got hart=%0d tnum=%0h exp hart=%0d tnum=%0h", it, fh2, ft2, fh_exp, tn[fh_exp]);
            end
            checks++;
            if (wc2 !== 32'(cnt)) begin
                errors++; $display("FAIL rand_wrcnt it=%0d got=%0d exp=%0d", it, wc2, cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_two_hart();
        test_done_on_timeout();
        test_wrcnt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
